pc_sequencer: RTL and testbench

Next-PC controller for the fetch stage: drives the write-enable, lock and data input of the 32-bit PC register (reset value 0xFFFF_FFFC) and reads its current value back. Arbitrates between sequential fetch, branch/jump redirects from EX and exception entry. Holds the PC during I-cache misses and load-use hazards. Captures any redirect that arrives while an I-cache miss is outstanding and replays it when the miss completes.

---
 rtl/pc_sequencer.sv | 110 +++++++++++
 tb/tb_pc_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: sequential fetch, EX redirects and exception entry.
// A redirect that arrives during an I-cache miss is held in PEND and applied when the miss releases.
module pc_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_1000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_cur,
  input  logic             icache_stall,
  input  logic             hazard_stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             exc_req,
  input  logic             perf_clr,
  output logic [31:0]      pc_next,
  output logic             pc_we,
  output logic             pc_lock,
  output logic             if_flush,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] pend_target;
  logic        pend_is_exc;
  logic        redir;
  logic [31:0] redir_target;
  logic [31:0] pc_seq;
  logic        capture;
  logic        upgrade;

  assign redir        = exc_req | br_taken;
  assign redir_target = exc_req ? EXC_VECTOR : {br_target[31:2], 2'b00};
  assign pc_seq       = pc_cur + 32'd4;

  // A pending branch yields to a later exception; a pending exception is never displaced.
  assign capture = (state == RUN)  && icache_stall && redir;
  assign upgrade = (state == PEND) && icache_stall && exc_req && !pend_is_exc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:  if (capture)       state_nxt = PEND;
      PEND: if (!icache_stall) state_nxt = RUN;
      default:                 state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_next  = pc_seq;
    pc_we    = 1'b0;
    pc_lock  = 1'b0;
    if_flush = 1'b0;
    case (state)
      RUN: begin
        if (icache_stall) begin
          pc_lock = 1'b1;
        end else if (redir) begin
          pc_next  = redir_target;
          pc_we    = 1'b1;
          if_flush = 1'b1;
        end else if (hazard_stall) begin
          pc_lock = 1'b1;
        end else begin
          pc_we = 1'b1;
        end
      end
      PEND: begin
        if (icache_stall) begin
          pc_lock = 1'b1;
        end else begin
          pc_next  = exc_req ? EXC_VECTOR : pend_target;
          pc_we    = 1'b1;
          if_flush = 1'b1;
        end
      end
      default: pc_lock = 1'b1;
    endcase
  end

  assign redirect_pending = (state == PEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_target <= 32'd0;
      pend_is_exc <= 1'b0;
    end else if (capture) begin
      pend_target <= redir_target;
      pend_is_exc <= exc_req;
    end else if (upgrade) begin
      pend_target <= EXC_VECTOR;
      pend_is_exc <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               stall_cycles <= '0;
    else if (perf_clr)                     stall_cycles <= '0;
    else if (pc_lock && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expectations queued as each cycle is driven, checked on the falling edge.
module tb_pc_sequencer;
  localparam logic [31:0] EXC = 32'h0000_1000;
  localparam int          CW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pc_cur;
  logic          icache_stall, hazard_stall, br_taken, exc_req, perf_clr;
  logic [31:0]   br_target;
  logic [31:0]   pc_next;
  logic          pc_we, pc_lock, if_flush, redirect_pending;
  logic [CW-1:0] stall_cycles;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic          cn;
    logic [31:0]   nxt;
    logic          we, lock, flush, pend;
    logic          cs;
    logic [CW-1:0] stall;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  pc_sequencer #(.EXC_VECTOR(EXC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .icache_stall(icache_stall),
    .hazard_stall(hazard_stall), .br_taken(br_taken), .br_target(br_target),
    .exc_req(exc_req), .perf_clr(perf_clr), .pc_next(pc_next), .pc_we(pc_we),
    .pc_lock(pc_lock), .if_flush(if_flush), .redirect_pending(redirect_pending),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Environment model of the PC register the sequencer drives.
  always @(posedge clk or posedge rst) begin
    if (rst)                   pc_cur <= 32'hFFFF_FFFC;
    else if (pc_we && !pc_lock) pc_cur <= pc_next;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e.cn) chk({t, ".pc_next"}, pc_next, e.nxt);
      chk({t, ".pc_we"},    {31'd0, pc_we},            {31'd0, e.we});
      chk({t, ".pc_lock"},  {31'd0, pc_lock},          {31'd0, e.lock});
      chk({t, ".if_flush"}, {31'd0, if_flush},         {31'd0, e.flush});
      chk({t, ".pending"},  {31'd0, redirect_pending}, {31'd0, e.pend});
      if (e.cs) chk({t, ".stall"}, {16'd0, stall_cycles}, {16'd0, e.stall});
      chk({t, ".lock_and_we"}, {31'd0, pc_lock & pc_we},  32'd0);
      chk({t, ".flush_no_we"}, {31'd0, if_flush & ~pc_we}, 32'd0);
    end
  end

  function automatic exp_t E(input logic cn, input logic [31:0] nxt, input logic we,
                             input logic lock, input logic flush, input logic pend,
                             input logic [CW-1:0] stall);
    exp_t e;
    e.cn = cn; e.nxt = nxt; e.we = we; e.lock = lock; e.flush = flush;
    e.pend = pend; e.cs = 1'b1; e.stall = stall;
    return e;
  endfunction

  // One cycle: drive inputs just after the rising edge, optionally queue an expectation.
  task automatic cyc(input string tag, input logic ic, input logic hz, input logic br,
                     input logic [31:0] tgt, input logic exc, input logic clr,
                     input bit push, input exp_t e);
    icache_stall = ic; hazard_stall = hz; br_taken = br; br_target = tgt;
    exc_req = exc; perf_clr = clr;
    if (push) begin exp_q.push_back(e); tag_q.push_back(tag); end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t nul;
    nul = '0;
    rst = 1'b1;
    icache_stall = 0; hazard_stall = 0; br_taken = 0; br_target = 0; exc_req = 0; perf_clr = 0;
    repeat (2) @(posedge clk); #1;
    // During reset the outputs follow RUN rules on pc_cur=FFFF_FFFC.
    exp_q.push_back(E(1, 32'h0, 1, 0, 0, 0, 0)); tag_q.push_back("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    //       tag     ic hz br tgt            exc clr
    cyc("rel0",  0, 0, 0, 32'h0,         0, 0, 1, E(1, 32'h0,        1, 0, 0, 0, 0));
    cyc("rel1",  0, 0, 0, 32'h0,         0, 0, 1, E(1, 32'h4,        1, 0, 0, 0, 0));
    cyc("rel2",  0, 0, 0, 32'h0,         0, 0, 1, E(1, 32'h8,        1, 0, 0, 0, 0));
    cyc("go40",  0, 0, 1, 32'h40,        0, 0, 1, E(1, 32'h40,       1, 0, 1, 0, 0));
    cyc("hz1",   0, 1, 0, 32'h0,         0, 0, 1, E(1, 32'h44,       0, 1, 0, 0, 0));
    cyc("hz2",   0, 1, 0, 32'h0,         0, 0, 1, E(1, 32'h44,       0, 1, 0, 0, 1));
    cyc("hz3",   0, 1, 0, 32'h0,         0, 0, 1, E(1, 32'h44,       0, 1, 0, 0, 2));
    cyc("hzend", 0, 0, 0, 32'h0,         0, 0, 1, E(1, 32'h44,       1, 0, 0, 0, 3));
    cyc("hzb1",  0, 1, 0, 32'h0,         0, 0, 1, E(1, 32'h48,       0, 1, 0, 0, 3));
    cyc("hzbr",  0, 1, 1, 32'h200,       0, 0, 1, E(1, 32'h200,      1, 0, 1, 0, 4));
    cyc("hzb3",  0, 1, 0, 32'h0,         0, 0, 1, E(1, 32'h204,      0, 1, 0, 0, 4));
    cyc("hzb4",  0, 0, 0, 32'h0,         0, 0, 1, E(1, 32'h204,      1, 0, 0, 0, 5));
    // I-cache miss, branch to 0x123 captured in miss cycle 2
    cyc("ic1",   1, 0, 0, 32'h0,         0, 0, 1, E(0, 32'h0,        0, 1, 0, 0, 5));
    cyc("ic2br", 1, 0, 1, 32'h123,       0, 0, 1, E(0, 32'h0,        0, 1, 0, 0, 6));
    cyc("ic3",   1, 0, 0, 32'h0,         0, 0, 1, E(0, 32'h0,        0, 1, 0, 1, 7));
    cyc("ic4",   1, 0, 0, 32'h0,         0, 0, 1, E(0, 32'h0,        0, 1, 0, 1, 8));
    cyc("ic5",   1, 0, 0, 32'h0,         0, 0, 1, E(0, 32'h0,        0, 1, 0, 1, 9));
    cyc("icrel", 0, 1, 0, 32'h0,         0, 0, 1, E(1, 32'h120,      1, 0, 1, 1, 10));
    cyc("icpost",0, 0, 0, 32'h0,         0, 0, 1, E(1, 32'h124,      1, 0, 0, 0, 10));
    // pending branch upgraded by exception
    cyc("pb1",   1, 0, 1, 32'h300,       0, 0, 1, E(0, 32'h0,        0, 1, 0, 0, 10));
    cyc("pbexc", 1, 0, 0, 32'h0,         1, 0, 1, E(0, 32'h0,        0, 1, 0, 1, 11));
    cyc("pbrel", 0, 0, 0, 32'h0,         0, 0, 1, E(1, EXC,          1, 0, 1, 1, 12));
    // pending exception not displaced by a later branch
    cyc("pe1",   1, 0, 0, 32'h0,         1, 0, 1, E(0, 32'h0,        0, 1, 0, 0, 12));
    cyc("pebr",  1, 0, 1, 32'h500,       0, 0, 1, E(0, 32'h0,        0, 1, 0, 1, 13));
    cyc("perel", 0, 0, 1, 32'h600,       0, 0, 1, E(1, EXC,          1, 0, 1, 1, 14));
    // exception arriving in the release cycle beats the pending branch
    cyc("px1",   1, 0, 1, 32'h700,       0, 0, 1, E(0, 32'h0,        0, 1, 0, 0, 14));
    cyc("pxrel", 0, 0, 0, 32'h0,         1, 0, 1, E(1, EXC,          1, 0, 1, 1, 15));
    // RUN-state priority and wrap
    cyc("excbr", 0, 0, 1, 32'h800,       1, 0, 1, E(1, EXC,          1, 0, 1, 0, 15));
    cyc("brtop", 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 1, E(1, 32'hFFFF_FFFC, 1, 0, 1, 0, 15));
    cyc("wrap",  0, 0, 0, 32'h0,         0, 0, 1, E(1, 32'h0,        1, 0, 0, 0, 15));
    // counter saturation
    for (int i = 0; i < (1 << CW) + 5; i++)
      cyc("sat", 0, 1, 0, 32'h0, 0, 0, 0, nul);
    cyc("satchk",0, 1, 0, 32'h0,         0, 0, 1, E(1, 32'h4,        0, 1, 0, 0, 16'hFFFF));
    cyc("clr",   0, 1, 0, 32'h0,         0, 1, 1, E(1, 32'h4,        0, 1, 0, 0, 16'hFFFF));
    cyc("clred", 0, 1, 0, 32'h0,         0, 0, 1, E(1, 32'h4,        0, 1, 0, 0, 0));
    cyc("recnt", 0, 0, 0, 32'h0,         0, 0, 1, E(1, 32'h4,        1, 0, 0, 0, 1));

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
